// File: rtl/md_hazard_ctrl.sv
// rtl/md_hazard_ctrl.sv - stall/flush controller with multiply/divide busy sequencing
//
// Purpose:
//   Central hazard controller for a five-stage pipeline. It compares the
//   D-stage source registers and their Tuse against the E/M destinations and
//   their Tnew. It also tracks the multi-cycle multiply/divide unit so that
//   D-stage md instructions wait until the unit is free.
//
// Ports:
//   clk          pipeline clock
//   reset        asynchronous active-low reset
//   D_rs, D_rt   D-stage source register numbers
//   D_tuse_rs/rt cycles until each source is consumed (3 = unused)
//   D_is_md      D-stage instruction touches the md unit or HI/LO
//   E_wa, E_tnew E-stage destination (0 = none) and cycles until its result
//   E_md_start   E-stage instruction launches a mult/div this cycle
//   E_md_is_div  launched op is a divide (else multiply)
//   M_wa, M_tnew M-stage destination (0 = none) and cycles until its result
//   stall        hold the F/D registers and PC
//   flush_E      load a nop bubble into the E register
//   md_busy      md unit occupied
//   md_done      one-cycle pulse on the last busy cycle
//   stall_cnt    saturating count of stalled cycles

module md_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  output logic        stall,
  output logic        flush_E,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  logic haz_rs;
  logic haz_rt;
  logic md_stall;

  // Tnew never exceeds 2, so a Tuse of 3 can never satisfy Tnew > Tuse.
  assign haz_rs = (D_rs != 5'd0) &
                  (((D_rs == E_wa) & (E_tnew > D_tuse_rs)) |
                   ((D_rs == M_wa) & (M_tnew > D_tuse_rs)));

  assign haz_rt = (D_rt != 5'd0) &
                  (((D_rt == E_wa) & (E_tnew > D_tuse_rt)) |
                   ((D_rt == M_wa) & (M_tnew > D_tuse_rt)));

  // The launch cycle is covered by E_md_start since state is still IDLE then.
  assign md_stall = D_is_md & (E_md_start | (state_q == BUSY));

  assign stall   = haz_rs | haz_rt | md_stall;
  assign flush_E = stall;
  assign md_busy = (state_q == BUSY);
  assign md_done = (state_q == BUSY) & (cnt_q == 4'd1);

  // A start seen while BUSY is a protocol violation and is deliberately
  // ignored: no reload, countdown continues undisturbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (E_md_start) begin
            state_q <= BUSY;
            cnt_q   <= E_md_is_div ? DIV_LD : MULT_LD;
          end
        end
        BUSY: begin
          if (cnt_q > 4'd1) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
